// File: rtl/drm_sfifo_ctrl.sv
// -----------------------------------------------------------------------------
// drm_sfifo_ctrl
//
// Controller for a synchronous FIFO backed by an external simple dual-port RAM.
// The RAM has a one-cycle read latency and no output register. A small
// two-entry output buffer hides that latency. With in_valid and out_ready both
// held high, one word moves in and one word moves out on every clock.
//
// Data path:
//   write stream -> RAM (write port) -> RAM (read port) -> 2-entry buffer
//                -> read stream
//
// Ports:
//   clk          single clock; all state updates on the rising edge
//   rst          synchronous active-high reset
//   in_data      write-stream word
//   in_valid     write-stream valid
//   in_ready     write-stream ready (RAM not full, not in reset)
//   out_data     read-stream word (head of output buffer; 0 during reset)
//   out_valid    read-stream valid (output buffer non-empty)
//   out_ready    read-stream ready
//   count        total words held: RAM + in-flight read + output buffer
//   ram_wr_en    RAM write enable (high exactly on an accepted push)
//   ram_wr_addr  RAM write address
//   ram_wr_data  RAM write data
//   ram_rd_addr  RAM read address, sampled by the RAM every cycle
//   ram_rd_data  RAM read data, valid one cycle after the address
// -----------------------------------------------------------------------------
module drm_sfifo_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  // One extra pointer bit tells a full RAM apart from an empty one.
  localparam logic [PTR_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Pointer state (modulo 2**PTR_W).
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      ram_used;

  // A RAM read was issued last cycle; its data is on ram_rd_data now.
  logic                  inflight;

  // Two-entry output buffer. head_q is always the oldest word.
  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;

  logic                  push;
  logic                  pop;
  logic                  fetch;
  logic [2:0]            occ_next;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is assigned on every path, so no latch is
  // inferred.
  always_comb begin
    // ram_used comes only from registered pointers. A push in this cycle does
    // not show up until next cycle. So a fetch can never read the address that
    // is being written at this same edge.
    ram_used    = wr_ptr - rd_ptr;

    in_ready    = !rst && (ram_used != DEPTH);
    push        = in_valid && in_ready;

    ram_wr_en   = push;
    ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    ram_wr_data = in_data;
    ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    out_valid   = !rst && (buf_cnt != 2'd0);
    out_data    = rst ? '0 : head_q;
    pop         = out_valid && out_ready;

    // Buffer occupancy after this edge, counting the in-flight word. A new
    // fetch is issued only if its data is sure to find a free slot.
    occ_next    = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    fetch       = !rst && (ram_used != '0) && (occ_next < 3'd2);

    count       = rst ? '0
                      : ram_used + PTR_W'(inflight) + PTR_W'(buf_cnt);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      buf_cnt  <= 2'd0;
      // NOTE: the two buffer words are cleared too (only two registers, so it
      // is cheap). The RAM array is external and never cleared: the pointers
      // alone decide which RAM words are valid.
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (fetch) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      inflight <= fetch;

      unique case ({inflight, pop})
        2'b10: begin
          // Capture only: append at the tail.
          if (buf_cnt == 2'd0) begin
            head_q <= ram_rd_data;
          end else begin
            tail_q <= ram_rd_data;
          end
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          // Pop only: shift the tail word up to the head.
          head_q  <= tail_q;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          // Capture and pop together: occupancy stays the same and order is
          // kept.
          if (buf_cnt == 2'd1) begin
            head_q <= ram_rd_data;
          end else begin
            head_q <= tail_q;
            tail_q <= ram_rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
